// File: rtl/delay_tap_monitor.sv
// rtl/delay_tap_monitor.sv - delay-chain launch/capture controller with averaged tap-count output

module tap_popcount #(
  parameter int W  = 101,
  parameter int CW = 7
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end
endmodule

module tap_bubble_detect #(
  parameter int W = 101
) (
  input  logic [W-1:0] bits,
  output logic         bubble
);
  // A set bit directly above a clear bit breaks the thermometer code.
  assign bubble = |(bits[W-1:1] & ~bits[W-2:0]);
endmodule

module delay_tap_monitor #(
  parameter int TAPS     = 101,
  parameter int CNT_W    = 7,
  parameter int AVG_LOG2 = 4,
  parameter int SETTLE   = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      launch,
  input  logic [TAPS-1:0]           taps,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CNT_W+AVG_LOG2-1:0] sum,
  output logic [CNT_W-1:0]          avg,
  output logic                      bubble_err
);
  localparam int AW  = CNT_W + AVG_LOG2;
  localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int NS  = 1 << AVG_LOG2;
  localparam logic [SCW-1:0]      SETTLE_LOAD = SCW'(SETTLE - 1);
  localparam logic [AVG_LOG2:0]   LAST_SAMPLE = (AVG_LOG2 + 1)'(NS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARM  = 3'd1,
    FIRE = 3'd2,
    CAP  = 3'd3,
    ACC  = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, next_state;

  logic [SCW-1:0]    settle_cnt;
  logic [AVG_LOG2:0] sample_cnt;
  logic [AW-1:0]     acc;
  logic              bub_acc;
  logic [TAPS-1:0]   tap_q, tap_q2;
  logic [CNT_W-1:0]  pop;
  logic              snap_bubble;

  tap_popcount #(.W(TAPS), .CW(CNT_W)) u_popcount (
    .bits  (tap_q2),
    .count (pop)
  );

  tap_bubble_detect #(.W(TAPS)) u_bubble (
    .bits   (tap_q2),
    .bubble (snap_bubble)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = ARM;
      ARM:  if (settle_cnt == '0) next_state = FIRE;
      FIRE: next_state = CAP;
      CAP:  next_state = ACC;
      ACC:  next_state = (sample_cnt == LAST_SAMPLE) ? DONE : ARM;
      DONE: if (out_valid && out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // launch is registered so the tap capture lands exactly one period after it rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      launch     <= 1'b0;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      sum        <= '0;
      avg        <= '0;
      bubble_err <= 1'b0;
      settle_cnt <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      bub_acc    <= 1'b0;
      tap_q      <= '0;
      tap_q2     <= '0;
    end else begin
      launch <= (next_state == FIRE);
      case (state)
        IDLE: begin
          if (start) begin
            acc        <= '0;
            sample_cnt <= '0;
            bub_acc    <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
          end
        end
        ARM: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        FIRE: tap_q  <= taps;
        CAP:  tap_q2 <= tap_q;
        ACC: begin
          acc        <= acc + AW'(pop);
          bub_acc    <= bub_acc | snap_bubble;
          sample_cnt <= (sample_cnt == LAST_SAMPLE) ? '0 : sample_cnt + 1'b1;
          settle_cnt <= SETTLE_LOAD;
        end
        DONE: begin
          // Results latch once on arrival and then hold through the handshake.
          if (!out_valid) begin
            sum        <= acc;
            avg        <= acc[AW-1:AVG_LOG2];
            bubble_err <= bub_acc;
            out_valid  <= 1'b1;
            busy       <= 1'b0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_delay_tap_monitor.sv
// tb/tb_delay_tap_monitor.sv - randomized self-checking bench for delay_tap_monitor

module tb_delay_tap_monitor;
  localparam int TAPS = 101;
  localparam int CNT_W = 7;
  localparam int AVG_LOG2 = 4;
  localparam int SETTLE = 8;
  localparam int N = 1 << AVG_LOG2;
  localparam int LAT = N * (SETTLE + 3) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic [TAPS-1:0] taps = '0;
  logic launch, busy, out_valid, bubble_err;
  logic [CNT_W+AVG_LOG2-1:0] sum;
  logic [CNT_W-1:0] avg;

  delay_tap_monitor #(.TAPS(TAPS), .CNT_W(CNT_W), .AVG_LOG2(AVG_LOG2), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .launch     (launch),
    .taps       (taps),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .avg        (avg),
    .bubble_err (bubble_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  logic [TAPS-1:0] pats [N];
  int exp_sum;
  logic exp_bub;

  function automatic logic [TAPS-1:0] rand_taps();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[TAPS-1:0];
  endfunction

  function automatic logic [TAPS-1:0] therm(input int c);
    logic [TAPS-1:0] p;
    for (int i = 0; i < TAPS; i++) p[i] = (i < c);
    return p;
  endfunction

  function automatic int ones(input logic [TAPS-1:0] p);
    int c = 0;
    for (int i = 0; i < TAPS; i++) c += int'(p[i]);
    return c;
  endfunction

  // mode 0: all snapshots thermometer c; 1: same plus one 3'b101 snapshot; 2: random
  task automatic build(input int mode, input int c);
    int bad_idx;
    int flip;
    bad_idx = $urandom_range(0, N - 1);
    exp_sum = 0;
    exp_bub = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (mode == 2) begin
        pats[s] = therm($urandom_range(0, TAPS));
        if ($urandom_range(0, 3) == 0) begin
          flip = $urandom_range(0, TAPS - 1);
          pats[s][flip] = ~pats[s][flip];
        end
      end else begin
        pats[s] = therm(c);
        if (mode == 1 && s == bad_idx) begin
          pats[s] = '0;
          pats[s][0] = 1'b1;
          pats[s][2] = 1'b1;
        end
      end
      exp_sum += ones(pats[s]);
      if (pats[s] != therm(ones(pats[s]))) exp_bub = 1'b1;
    end
  endtask

  task automatic run_meas(input string tag);
    int n = 0, pulses = 0, low_run = 0, hi_run = 0;
    int bad_width = 0, bad_settle = 0, busy_drop = 0, idx = 0;
    start = 1'b1;
    taps = rand_taps();
    @(negedge clk);
    start = 1'b0;
    chk({tag, " busy_rise"}, 32'(busy), 1);
    while (!out_valid && n < 1000) begin
      if (launch) begin
        if (hi_run == 0) begin
          pulses++;
          if (low_run < SETTLE) bad_settle++;
        end
        hi_run++;
        if (hi_run > 1) bad_width++;
        low_run = 0;
        taps = pats[idx % N];
        idx++;
      end else begin
        hi_run = 0;
        low_run++;
        taps = rand_taps();
      end
      if (!busy) busy_drop++;
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), LAT);
    chk({tag, " pulses"}, 32'(pulses), N);
    chk({tag, " pulse_width"}, 32'(bad_width), 0);
    chk({tag, " settle_low"}, 32'(bad_settle), 0);
    chk({tag, " busy_held"}, 32'(busy_drop), 0);
    chk({tag, " busy_done"}, 32'(busy), 0);
    chk({tag, " sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, " avg"}, 32'(avg), 32'(exp_sum / N));
    chk({tag, " bubble"}, 32'(bubble_err), 32'(exp_bub));
  endtask

  task automatic handshake(input string tag, input logic hs_start);
    out_ready = 1'b1;
    start = hs_start;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    chk({tag, " valid_drop"}, 32'(out_valid), 0);
    chk({tag, " idle_busy"}, 32'(busy), 0);
  endtask

  task automatic hold_test();
    int unstable = 0;
    logic [CNT_W+AVG_LOG2-1:0] s0;
    logic [CNT_W-1:0] a0;
    logic b0;
    s0 = sum;
    a0 = avg;
    b0 = bubble_err;
    for (int i = 0; i < 20; i++) begin
      start = (i == 5);
      taps = rand_taps();
      @(negedge clk);
      if (sum !== s0 || avg !== a0 || bubble_err !== b0 || !out_valid || launch || busy)
        unstable++;
    end
    start = 1'b0;
    chk("hold stable", 32'(unstable), 0);
  endtask

  initial begin
    int launches = 0;
    int nonzero = 0;
    int waited = 0;
    repeat (3) @(negedge clk);
    chk("rst launch", 32'(launch), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst valid", 32'(out_valid), 0);
    chk("rst sum", 32'(sum), 0);
    chk("rst avg", 32'(avg), 0);
    chk("rst bubble", 32'(bubble_err), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      taps = rand_taps();
      @(negedge clk);
      if (launch) launches++;
      if (busy || out_valid || sum != 0 || avg != 0 || bubble_err) nonzero++;
    end
    chk("idle launches", 32'(launches), 0);
    chk("idle outputs", 32'(nonzero), 0);

    build(0, 37);
    run_meas("t37");
    chk("t37 sum_const", 32'(sum), 592);
    hold_test();
    handshake("hs0", 1'b0);

    build(1, 37);
    run_meas("bub");
    chk("bub sum_const", 32'(sum), 557);
    chk("bub avg_const", 32'(avg), 34);
    handshake("hs_start", 1'b1);
    build(0, 50);
    run_meas("clean");
    handshake("hs1", 1'b0);

    build(0, TAPS);
    run_meas("full");
    chk("full sum_const", 32'(sum), 1616);
    handshake("hs2", 1'b0);
    build(0, 0);
    run_meas("empty");
    handshake("hs3", 1'b0);

    for (int r = 0; r < 4; r++) begin
      build(2, 0);
      run_meas("rand");
      handshake("hsr", 1'b0);
    end

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!launch && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("fire reached", 32'(launch), 1);
    rst_n = 1'b0;
    #1;
    chk("async launch", 32'(launch), 0);
    chk("async busy", 32'(busy), 0);
    chk("async valid", 32'(out_valid), 0);
    chk("async sum", 32'(sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    build(0, 37);
    run_meas("post_rst");
    handshake("hs4", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
